// File: rtl/alu_seq.sv
// alu_seq: 8-function ALU with multi-cycle bit-serial shifter and registered result/flags.
// Latency: non-shift ops and zero-count shifts complete at the accept edge; shifts by n>=1 take n more edges.
// Backpressure: busy_o=1 while a shift runs; start_i is ignored then. start_i is accepted again in the done_o cycle.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous active-high reset
//   start_i         operation request (accepted only when busy_o=0)
//   func_i[2:0]     000 SUB, 001 XOR, 010 PASS A, 011 PASS B, 100 ADD, 101 AND, 110 SHL, 111 SHR
//   a_i, b_i        operands; b_i[SHIFT_BITS-1:0] is the shift count
//   c_in_i          carry-in (ADD) / borrow-in (SUB)
//   out_o           registered result
//   c_out_o, z_out_o, n_out_o, v_out_o   carry/borrow, zero, negative, signed overflow
//   busy_o          shift in progress
//   done_o          one-cycle completion pulse
module alu_seq #(
   parameter int WIDTH      = 16,
   parameter int SHIFT_BITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [2:0]            func_i,
   input  logic [WIDTH-1:0]      a_i,
   input  logic [WIDTH-1:0]      b_i,
   input  logic                  c_in_i,
   output logic [WIDTH-1:0]      out_o,
   output logic                  c_out_o,
   output logic                  z_out_o,
   output logic                  n_out_o,
   output logic                  v_out_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [2:0] F_SUB  = 3'b000;
   localparam logic [2:0] F_XOR  = 3'b001;
   localparam logic [2:0] F_PASA = 3'b010;
   localparam logic [2:0] F_PASB = 3'b011;
   localparam logic [2:0] F_ADD  = 3'b100;
   localparam logic [2:0] F_AND  = 3'b101;
   localparam logic [2:0] F_SHL  = 3'b110;
   localparam logic [2:0] F_SHR  = 3'b111;

   localparam logic [SHIFT_BITS-1:0] CNT_ONE  = {{(SHIFT_BITS-1){1'b0}}, 1'b1};
   localparam logic [SHIFT_BITS-1:0] CNT_ZERO = '0;

   state_t                state_q;
   logic [WIDTH-1:0]      shreg_q;
   logic [SHIFT_BITS-1:0] cnt_q;
   logic                  dir_q;      // 1 = shift right
   logic [WIDTH-1:0]      out_q;
   logic                  c_q, z_q, n_q, v_q;
   logic                  busy_q, done_q;

   logic [WIDTH:0]        sum_w, dif_w;
   logic [WIDTH-1:0]      res_d;
   logic                  c_d, v_d;
   logic [WIDTH-1:0]      sh_next_d;
   logic                  sh_bit_d;
   logic [SHIFT_BITS-1:0] shamt;
   logic                  is_shift;

   assign shamt    = b_i[SHIFT_BITS-1:0];
   assign is_shift = (func_i == F_SHL) || (func_i == F_SHR);

   // One extra bit catches the carry (ADD) or the borrow (SUB): a negative
   // difference wraps with bit WIDTH set.
   assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_in_i};
   assign dif_w = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, c_in_i};

   // Single-cycle result; shifts only take this path with a zero count.
   always_comb begin
      res_d = a_i;
      c_d   = 1'b0;
      v_d   = 1'b0;
      case (func_i)
         F_SUB: begin
            res_d = dif_w[WIDTH-1:0];
            c_d   = dif_w[WIDTH];
            v_d   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
         end
         F_ADD: begin
            res_d = sum_w[WIDTH-1:0];
            c_d   = sum_w[WIDTH];
            v_d   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
         end
         F_XOR:  res_d = a_i ^ b_i;
         F_AND:  res_d = a_i & b_i;
         F_PASA: res_d = a_i;
         F_PASB: res_d = b_i;
         F_SHL,
         F_SHR:  res_d = a_i;
         default: res_d = a_i;
      endcase
   end

   // One shift step; the bit leaving the register on the final step is the carry.
   always_comb begin
      sh_next_d = dir_q ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
      sh_bit_d  = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         out_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (is_shift && (shamt != CNT_ZERO)) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                     shreg_q <= a_i;
                     cnt_q   <= shamt;
                     dir_q   <= func_i[0];
                  end else begin
                     out_q  <= res_d;
                     c_q    <= c_d;
                     v_q    <= v_d;
                     z_q    <= (res_d == '0);
                     n_q    <= res_d[WIDTH-1];
                     done_q <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               shreg_q <= sh_next_d;
               cnt_q   <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  out_q   <= sh_next_d;
                  c_q     <= sh_bit_d;
                  v_q     <= 1'b0;
                  z_q     <= (sh_next_d == '0);
                  n_q     <= sh_next_d[WIDTH-1];
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_o   = out_q;
   assign c_out_o = c_q;
   assign z_out_o = z_q;
   assign n_out_o = n_q;
   assign v_out_o = v_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule
